// File: rtl/int_img_stream_if.sv
// Stream bundle for int_img_stream: pixel input handshake, integral output
// handshake and the sticky start-of-frame error flag.
interface int_img_stream_if #(
  parameter int IMG_WIDTH  = 24,
  parameter int IMG_HEIGHT = 24,
  parameter int PIX_W      = 8,
  parameter int II_W       = 32,
  parameter int SQ_W       = 32
);
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);

  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pix;
  logic             in_sof;
  logic             out_valid;
  logic             out_ready;
  logic [II_W-1:0]  out_ii;
  logic [SQ_W-1:0]  out_sq;
  logic [XW-1:0]    out_x;
  logic [YW-1:0]    out_y;
  logic             out_eol;
  logic             out_eof;
  logic             sof_err;

  // Producer of pixels / consumer of integral values
  modport master (
    output in_valid, in_pix, in_sof, out_ready,
    input  in_ready, out_valid, out_ii, out_sq, out_x, out_y, out_eol, out_eof, sof_err
  );

  // The integral-image block itself
  modport slave (
    input  in_valid, in_pix, in_sof, out_ready,
    output in_ready, out_valid, out_ii, out_sq, out_x, out_y, out_eol, out_eof, sof_err
  );
endinterface

// File: rtl/int_img_stream.sv
// Streaming integral-image / squared-integral-image calculator.
// One pixel per cycle in raster order; one output register (latency 1).
// A single line buffer holds the previous row's ii/sq values; the first_row
// flag masks its stale contents so it never needs clearing.
module int_img_stream #(
  parameter int IMG_WIDTH  = 24,
  parameter int IMG_HEIGHT = 24,
  parameter int PIX_W      = 8,
  parameter int II_W       = 32,
  parameter int SQ_W       = 32,
  parameter bit SQ_EN      = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  int_img_stream_if.slave bus
);
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  // Zero-extend a pixel into the ii accumulator width (truncates if narrower)
  function automatic logic [II_W-1:0] ext_ii(input logic [PIX_W-1:0] v);
    logic [II_W+PIX_W-1:0] w;
    w = {{II_W{1'b0}}, v};
    return w[II_W-1:0];
  endfunction

  // Zero-extend a squared pixel into the sq accumulator width
  function automatic logic [SQ_W-1:0] ext_sq(input logic [2*PIX_W-1:0] v);
    logic [SQ_W+2*PIX_W-1:0] w;
    w = {{SQ_W{1'b0}}, v};
    return w[SQ_W-1:0];
  endfunction

  logic            acc;
  logic            sof_mid;
  logic [XW-1:0]   x_cur;
  logic [YW-1:0]   y_cur;
  logic            first_cur;
  logic            eol_cur;
  logic            eof_cur;
  logic [II_W-1:0] rs;
  logic [II_W-1:0] ii_new;

  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            first_q, first_d;
  logic [II_W-1:0] rowsum_q, rowsum_d;
  logic            sof_err_q, sof_err_d;
  logic            ov_q, ov_d;
  logic [II_W-1:0] ii_q, ii_d;
  logic [XW-1:0]   ox_q, ox_d;
  logic [YW-1:0]   oy_q, oy_d;
  logic            eol_q, eol_d;
  logic            eof_q, eof_d;

  logic [II_W-1:0] lb_ii [IMG_WIDTH];

  assign bus.in_ready = !ov_q || bus.out_ready;
  assign acc          = bus.in_valid && bus.in_ready;

  // Position of the incoming pixel, ii arithmetic and all next-state values
  always_comb begin
    sof_mid   = bus.in_sof && ((x_q != '0) || (y_q != '0));
    x_cur     = sof_mid ? '0 : x_q;
    y_cur     = sof_mid ? '0 : y_q;
    first_cur = sof_mid ? 1'b1 : first_q;
    eol_cur   = (x_cur == X_LAST);
    eof_cur   = eol_cur && (y_cur == Y_LAST);
    rs        = ((x_cur == '0) ? '0 : rowsum_q) + ext_ii(bus.in_pix);
    ii_new    = rs + (first_cur ? '0 : lb_ii[x_cur]);

    x_d       = x_q;
    y_d       = y_q;
    first_d   = first_q;
    rowsum_d  = rowsum_q;
    sof_err_d = sof_err_q;
    ov_d      = ov_q;
    ii_d      = ii_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    eol_d     = eol_q;
    eof_d     = eof_q;

    if (acc) begin
      ov_d      = 1'b1;
      ii_d      = ii_new;
      ox_d      = x_cur;
      oy_d      = y_cur;
      eol_d     = eol_cur;
      eof_d     = eof_cur;
      rowsum_d  = rs;
      sof_err_d = sof_err_q || sof_mid;
      if (eof_cur) begin
        x_d     = '0;
        y_d     = '0;
        first_d = 1'b1;
      end else if (eol_cur) begin
        x_d     = '0;
        y_d     = y_cur + YW'(1);
        first_d = 1'b0;
      end else begin
        x_d     = x_cur + XW'(1);
        y_d     = y_cur;
        first_d = first_cur;
      end
    end else if (bus.out_ready) begin
      ov_d = 1'b0;
    end
  end

  // Control, counters and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q       <= '0;
      y_q       <= '0;
      first_q   <= 1'b1;
      rowsum_q  <= '0;
      sof_err_q <= 1'b0;
      ov_q      <= 1'b0;
      ii_q      <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      eol_q     <= 1'b0;
      eof_q     <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      first_q   <= first_d;
      rowsum_q  <= rowsum_d;
      sof_err_q <= sof_err_d;
      ov_q      <= ov_d;
      ii_q      <= ii_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      eol_q     <= eol_d;
      eof_q     <= eof_d;
    end
  end

  // Line buffer: read-before-write at the current column, never reset
  always_ff @(posedge clk) begin
    if (acc) lb_ii[x_cur] <= ii_new;
  end

  assign bus.out_valid = ov_q;
  assign bus.out_ii    = ii_q;
  assign bus.out_x     = ox_q;
  assign bus.out_y     = oy_q;
  assign bus.out_eol   = eol_q;
  assign bus.out_eof   = eof_q;
  assign bus.sof_err   = sof_err_q;

  generate
    if (SQ_EN) begin : g_sq
      logic [2*PIX_W-1:0] psq;
      logic [SQ_W-1:0]    rq;
      logic [SQ_W-1:0]    sq_new;
      logic [SQ_W-1:0]    rowsq_q;
      logic [SQ_W-1:0]    sq_q;
      logic [SQ_W-1:0]    lb_sq [IMG_WIDTH];

      // Squared-pixel running sums, same structure as the ii path
      always_comb begin
        psq    = {{PIX_W{1'b0}}, bus.in_pix} * {{PIX_W{1'b0}}, bus.in_pix};
        rq     = ((x_cur == '0) ? '0 : rowsq_q) + ext_sq(psq);
        sq_new = rq + (first_cur ? '0 : lb_sq[x_cur]);
      end

      // Row sum and output register of the squared path
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rowsq_q <= '0;
          sq_q    <= '0;
        end else if (acc) begin
          rowsq_q <= rq;
          sq_q    <= sq_new;
        end
      end

      // Squared line buffer, read-before-write at the current column
      always_ff @(posedge clk) begin
        if (acc) lb_sq[x_cur] <= sq_new;
      end

      assign bus.out_sq = sq_q;
    end else begin : g_nosq
      assign bus.out_sq = '0;
    end
  endgenerate
endmodule

// File: tb/tb_int_img_stream.sv
// Bench for int_img_stream: 4x4 frames on a 32-bit instance and an 8-bit-ii
// instance, compared against a frame-array reference model.
module tb_int_img_stream;
  localparam int W = 4;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int_img_stream_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8), .II_W(32), .SQ_W(32)) b0 ();
  int_img_stream_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8), .II_W(8),  .SQ_W(32)) b1 ();

  int_img_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8), .II_W(32), .SQ_W(32), .SQ_EN(1'b1))
    u_dut (.clk(clk), .rst_n(rst_n), .bus(b0));
  int_img_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8), .II_W(8), .SQ_W(32), .SQ_EN(1'b1))
    u_dut8 (.clk(clk), .rst_n(rst_n), .bus(b1));

  int     n_checks = 0;
  int     n_pass = 0;
  int     stim_pix[$];
  bit     stim_sof[$];
  longint exp_ii[$], exp_sq[$], got_ii[$], got_sq[$];
  int     exp_x[$], exp_y[$], got_x[$], got_y[$];
  bit     exp_eol[$], exp_eof[$], got_eol[$], got_eof[$];
  int     acc_cyc[$], cap_cyc[$];
  int     rdy_viol;
  bit     timeout;
  int     m_x, m_y;
  int     img [H][W];

  // Reference: keep the current frame as a pixel array and sum rectangles.
  task automatic add_pix(input int pix, input bit sof, input int iiw);
    longint s = 0;
    longint q = 0;
    stim_pix.push_back(pix);
    stim_sof.push_back(sof);
    if (sof && (m_x != 0 || m_y != 0)) begin m_x = 0; m_y = 0; end
    if (m_x == 0 && m_y == 0)
      for (int yy = 0; yy < H; yy++) for (int xx = 0; xx < W; xx++) img[yy][xx] = 0;
    img[m_y][m_x] = pix;
    for (int yy = 0; yy <= m_y; yy++)
      for (int xx = 0; xx <= m_x; xx++) begin
        s += img[yy][xx];
        q += img[yy][xx] * img[yy][xx];
      end
    exp_ii.push_back(s & ((64'd1 << iiw) - 1));
    exp_sq.push_back(q & 64'hFFFF_FFFF);
    exp_x.push_back(m_x);
    exp_y.push_back(m_y);
    exp_eol.push_back(m_x == W - 1);
    exp_eof.push_back(m_x == W - 1 && m_y == H - 1);
    if (m_x == W - 1) begin
      m_x = 0;
      m_y = (m_y == H - 1) ? 0 : m_y + 1;
    end else m_x++;
  endtask

  task automatic clear_all();
    stim_pix.delete(); stim_sof.delete();
    exp_ii.delete(); exp_sq.delete(); exp_x.delete(); exp_y.delete();
    exp_eol.delete(); exp_eof.delete();
  endtask

  task automatic set_in(input int sel, input bit vld, input int pix, input bit sof, input bit r);
    if (sel == 0) begin
      b0.in_valid = vld; b0.in_pix = 8'(pix); b0.in_sof = sof; b0.out_ready = r;
      b1.in_valid = 1'b0; b1.out_ready = 1'b1;
    end else begin
      b1.in_valid = vld; b1.in_pix = 8'(pix); b1.in_sof = sof; b1.out_ready = r;
      b0.in_valid = 1'b0; b0.out_ready = 1'b1;
    end
  endtask

  // Drive stim_* into one instance and collect every output handshake.
  // ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  task automatic drive_stream(input int sel, input int ready_mode, input bit valid_rand);
    int idx = 0;
    int ncap = 0;
    int cyc = 0;
    int n = stim_pix.size();
    bit vld, r, ov, ir;
    got_ii.delete(); got_sq.delete(); got_x.delete(); got_y.delete();
    got_eol.delete(); got_eof.delete(); acc_cyc.delete(); cap_cyc.delete();
    rdy_viol = 0;
    timeout = 1'b0;
    while ((idx < n || ncap < n) && cyc < 2000) begin
      @(negedge clk);
      vld = (idx < n) && (!valid_rand || $urandom_range(0, 3) != 0);
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      set_in(sel, vld, vld ? stim_pix[idx] : 0, vld ? stim_sof[idx] : 1'b0, r);
      #1;
      ov = (sel == 0) ? b0.out_valid : b1.out_valid;
      ir = (sel == 0) ? b0.in_ready : b1.in_ready;
      if (ir !== (!ov || r)) rdy_viol++;
      if (ov && r) begin
        got_ii.push_back((sel == 0) ? longint'(b0.out_ii) : longint'(b1.out_ii));
        got_sq.push_back((sel == 0) ? longint'(b0.out_sq) : longint'(b1.out_sq));
        got_x.push_back((sel == 0) ? int'(b0.out_x) : int'(b1.out_x));
        got_y.push_back((sel == 0) ? int'(b0.out_y) : int'(b1.out_y));
        got_eol.push_back((sel == 0) ? b0.out_eol : b1.out_eol);
        got_eof.push_back((sel == 0) ? b0.out_eof : b1.out_eof);
        cap_cyc.push_back(cyc);
        ncap++;
      end
      if (vld && ir) begin
        acc_cyc.push_back(cyc);
        idx++;
      end
      cyc++;
    end
    if (idx < n || ncap < n) timeout = 1'b1;
    @(negedge clk);
    set_in(sel, 1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (b0.out_valid !== 1'b0) $display("FAIL rst_out_valid got %0d expected 0", b0.out_valid); else n_pass++;
    n_checks++; if (b0.out_ii !== 32'd0) $display("FAIL rst_out_ii got %0d expected 0", b0.out_ii); else n_pass++;
    n_checks++; if (b0.out_sq !== 32'd0) $display("FAIL rst_out_sq got %0d expected 0", b0.out_sq); else n_pass++;
    n_checks++; if (b0.out_x !== 2'd0 || b0.out_y !== 2'd0) $display("FAIL rst_xy got %0d,%0d expected 0,0", b0.out_x, b0.out_y); else n_pass++;
    n_checks++; if (b0.out_eol !== 1'b0 || b0.out_eof !== 1'b0) $display("FAIL rst_eol_eof got %0d,%0d expected 0,0", b0.out_eol, b0.out_eof); else n_pass++;
    n_checks++; if (b0.sof_err !== 1'b0) $display("FAIL rst_sof_err got %0d expected 0", b0.sof_err); else n_pass++;
    n_checks++; if (b0.in_ready !== 1'b1) $display("FAIL rst_in_ready got %0d expected 1", b0.in_ready); else n_pass++;
  endtask

  task automatic test_allconst();
    clear_all();
    for (int i = 0; i < W * H; i++) add_pix(2, i == 0, 32);
    drive_stream(0, 0, 1'b0);
    n_checks++;
    if (timeout || got_ii.size() != exp_ii.size()) $display("FAIL allc_count got %0d expected %0d", got_ii.size(), exp_ii.size()); else n_pass++;
    for (int i = 0; i < exp_ii.size() && i < got_ii.size(); i++) begin
      n_checks++;
      if (got_ii[i] !== exp_ii[i] || got_sq[i] !== exp_sq[i] || got_x[i] !== exp_x[i] || got_y[i] !== exp_y[i] || got_eol[i] !== exp_eol[i] || got_eof[i] !== exp_eof[i])
        $display("FAIL allc_out[%0d] got ii=%0d sq=%0d x=%0d y=%0d eol=%0d eof=%0d expected ii=%0d sq=%0d x=%0d y=%0d eol=%0d eof=%0d", i, got_ii[i], got_sq[i], got_x[i], got_y[i], got_eol[i], got_eof[i], exp_ii[i], exp_sq[i], exp_x[i], exp_y[i], exp_eol[i], exp_eof[i]);
      else n_pass++;
      n_checks++;
      if (cap_cyc[i] != acc_cyc[i] + 1) $display("FAIL allc_latency[%0d] got %0d cycles expected 1", i, cap_cyc[i] - acc_cyc[i]); else n_pass++;
    end
    if (got_ii.size() == 16) begin
      n_checks++;
      if (got_ii[15] !== 64'd32 || got_sq[15] !== 64'd64 || got_eof[15] !== 1'b1 || got_eol[15] !== 1'b1)
        $display("FAIL allc_last got ii=%0d sq=%0d eol=%0d eof=%0d expected 32 64 1 1", got_ii[15], got_sq[15], got_eol[15], got_eof[15]);
      else n_pass++;
    end
  endtask

  task automatic test_ramp();
    clear_all();
    for (int i = 0; i < W * H; i++) add_pix(i, 1'b0, 32);
    drive_stream(0, 0, 1'b0);
    n_checks++;
    if (timeout || got_ii.size() != exp_ii.size()) $display("FAIL ramp_count got %0d expected %0d", got_ii.size(), exp_ii.size()); else n_pass++;
    for (int i = 0; i < exp_ii.size() && i < got_ii.size(); i++) begin
      n_checks++;
      if (got_ii[i] !== exp_ii[i] || got_sq[i] !== exp_sq[i] || got_x[i] !== exp_x[i] || got_y[i] !== exp_y[i] || got_eol[i] !== exp_eol[i] || got_eof[i] !== exp_eof[i])
        $display("FAIL ramp_out[%0d] got ii=%0d sq=%0d x=%0d y=%0d expected ii=%0d sq=%0d x=%0d y=%0d", i, got_ii[i], got_sq[i], got_x[i], got_y[i], exp_ii[i], exp_sq[i], exp_x[i], exp_y[i]);
      else n_pass++;
    end
    if (got_ii.size() == 16) begin
      n_checks++;
      if (got_ii[15] !== 64'd120 || got_sq[15] !== 64'd1240 || got_ii[3] !== 64'd6 || got_ii[12] !== 64'd24)
        $display("FAIL ramp_corners got ii33=%0d sq33=%0d ii30=%0d ii03=%0d expected 120 1240 6 24", got_ii[15], got_sq[15], got_ii[3], got_ii[12]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    clear_all();
    for (int i = 0; i < W * H; i++) add_pix(2, 1'b0, 32);
    drive_stream(0, 1, 1'b0);
    n_checks++;
    if (rdy_viol != 0) $display("FAIL bp_in_ready got %0d violations expected 0", rdy_viol); else n_pass++;
    n_checks++;
    if (timeout || got_ii.size() != exp_ii.size()) $display("FAIL bp_count got %0d expected %0d", got_ii.size(), exp_ii.size()); else n_pass++;
    for (int i = 0; i < exp_ii.size() && i < got_ii.size(); i++) begin
      n_checks++;
      if (got_ii[i] !== exp_ii[i] || got_sq[i] !== exp_sq[i] || got_x[i] !== exp_x[i] || got_y[i] !== exp_y[i] || got_eof[i] !== exp_eof[i])
        $display("FAIL bp_out[%0d] got ii=%0d sq=%0d x=%0d y=%0d expected ii=%0d sq=%0d x=%0d y=%0d", i, got_ii[i], got_sq[i], got_x[i], got_y[i], exp_ii[i], exp_sq[i], exp_x[i], exp_y[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    clear_all();
    for (int i = 0; i < W * H; i++) add_pix(2, 1'b0, 32);
    for (int i = 0; i < W * H; i++) add_pix(1, 1'b0, 32);
    drive_stream(0, 0, 1'b0);
    n_checks++;
    if (timeout || got_ii.size() != exp_ii.size()) $display("FAIL b2b_count got %0d expected %0d", got_ii.size(), exp_ii.size()); else n_pass++;
    for (int i = 0; i < exp_ii.size() && i < got_ii.size(); i++) begin
      n_checks++;
      if (got_ii[i] !== exp_ii[i] || got_sq[i] !== exp_sq[i] || got_x[i] !== exp_x[i] || got_y[i] !== exp_y[i])
        $display("FAIL b2b_out[%0d] got ii=%0d sq=%0d x=%0d y=%0d expected ii=%0d sq=%0d x=%0d y=%0d", i, got_ii[i], got_sq[i], got_x[i], got_y[i], exp_ii[i], exp_sq[i], exp_x[i], exp_y[i]);
      else n_pass++;
    end
    if (got_ii.size() == 32) begin
      n_checks++;
      if (got_ii[31] !== 64'd16) $display("FAIL b2b_last_ii got %0d expected 16", got_ii[31]); else n_pass++;
    end
  endtask

  task automatic test_random();
    clear_all();
    for (int i = 0; i < 3 * W * H; i++) add_pix($urandom_range(0, 255), (i % (W * H)) == 0, 32);
    drive_stream(0, 2, 1'b1);
    n_checks++;
    if (rdy_viol != 0) $display("FAIL rnd_in_ready got %0d violations expected 0", rdy_viol); else n_pass++;
    n_checks++;
    if (timeout || got_ii.size() != exp_ii.size()) $display("FAIL rnd_count got %0d expected %0d", got_ii.size(), exp_ii.size()); else n_pass++;
    for (int i = 0; i < exp_ii.size() && i < got_ii.size(); i++) begin
      n_checks++;
      if (got_ii[i] !== exp_ii[i] || got_sq[i] !== exp_sq[i] || got_x[i] !== exp_x[i] || got_y[i] !== exp_y[i] || got_eol[i] !== exp_eol[i] || got_eof[i] !== exp_eof[i])
        $display("FAIL rnd_out[%0d] got ii=%0d sq=%0d x=%0d y=%0d expected ii=%0d sq=%0d x=%0d y=%0d", i, got_ii[i], got_sq[i], got_x[i], got_y[i], exp_ii[i], exp_sq[i], exp_x[i], exp_y[i]);
      else n_pass++;
    end
    n_checks++;
    if (b0.sof_err !== 1'b0) $display("FAIL rnd_sof_err got %0d expected 0", b0.sof_err); else n_pass++;
  endtask

  task automatic test_sof_mid();
    int p5;
    clear_all();
    for (int i = 0; i < 5; i++) add_pix($urandom_range(0, 255), i == 0, 32);
    p5 = $urandom_range(1, 255);
    add_pix(p5, 1'b1, 32);
    for (int i = 0; i < 15; i++) add_pix($urandom_range(0, 255), 1'b0, 32);
    drive_stream(0, 0, 1'b0);
    n_checks++;
    if (b0.sof_err !== 1'b1) $display("FAIL sof_err_set got %0d expected 1", b0.sof_err); else n_pass++;
    n_checks++;
    if (timeout || got_ii.size() != exp_ii.size()) $display("FAIL sof_count got %0d expected %0d", got_ii.size(), exp_ii.size()); else n_pass++;
    if (got_ii.size() > 5) begin
      n_checks++;
      if (got_x[5] !== 0 || got_y[5] !== 0 || got_ii[5] !== longint'(p5))
        $display("FAIL sof_pixel got x=%0d y=%0d ii=%0d expected 0 0 %0d", got_x[5], got_y[5], got_ii[5], p5);
      else n_pass++;
    end
    for (int i = 0; i < exp_ii.size() && i < got_ii.size(); i++) begin
      n_checks++;
      if (got_ii[i] !== exp_ii[i] || got_sq[i] !== exp_sq[i] || got_x[i] !== exp_x[i] || got_y[i] !== exp_y[i] || got_eof[i] !== exp_eof[i])
        $display("FAIL sof_out[%0d] got ii=%0d sq=%0d x=%0d y=%0d expected ii=%0d sq=%0d x=%0d y=%0d", i, got_ii[i], got_sq[i], got_x[i], got_y[i], exp_ii[i], exp_sq[i], exp_x[i], exp_y[i]);
      else n_pass++;
    end
  endtask

  task automatic test_wrap_reset();
    clear_all();
    for (int i = 0; i < W * H; i++) add_pix(255, 1'b0, 8);
    drive_stream(1, 0, 1'b0);
    n_checks++;
    if (timeout || got_ii.size() != exp_ii.size()) $display("FAIL wrap_count got %0d expected %0d", got_ii.size(), exp_ii.size()); else n_pass++;
    for (int i = 0; i < exp_ii.size() && i < got_ii.size(); i++) begin
      n_checks++;
      if (got_ii[i] !== exp_ii[i] || got_sq[i] !== exp_sq[i] || got_x[i] !== exp_x[i] || got_y[i] !== exp_y[i])
        $display("FAIL wrap_out[%0d] got ii=%0d sq=%0d expected ii=%0d sq=%0d", i, got_ii[i], got_sq[i], exp_ii[i], exp_sq[i]);
      else n_pass++;
    end
    if (got_ii.size() > 1) begin
      n_checks++;
      if (got_ii[1] !== 64'd254) $display("FAIL wrap_ii10 got %0d expected 254", got_ii[1]); else n_pass++;
    end
    // Part of a frame, then one more pixel held in the output register
    clear_all();
    for (int i = 0; i < 6; i++) add_pix($urandom_range(0, 255), 1'b0, 8);
    drive_stream(1, 0, 1'b0);
    set_in(1, 1'b1, 200, 1'b0, 1'b0);
    @(negedge clk);
    set_in(1, 1'b0, 0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (b1.out_valid !== 1'b1 || b1.out_x !== 2'd2 || b1.out_y !== 2'd1)
      $display("FAIL held_out got valid=%0d x=%0d y=%0d expected 1 2 1", b1.out_valid, b1.out_x, b1.out_y);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (b1.out_valid !== 1'b0 || b1.out_ii !== 8'd0 || b1.out_sq !== 32'd0 || b1.out_x !== 2'd0 || b1.out_y !== 2'd0 || b1.out_eol !== 1'b0 || b1.out_eof !== 1'b0)
      $display("FAIL midrst_outputs got valid=%0d ii=%0d sq=%0d x=%0d y=%0d eol=%0d eof=%0d expected all 0", b1.out_valid, b1.out_ii, b1.out_sq, b1.out_x, b1.out_y, b1.out_eol, b1.out_eof);
    else n_pass++;
    n_checks++;
    if (b0.sof_err !== 1'b0) $display("FAIL midrst_sof_err got %0d expected 0", b0.sof_err); else n_pass++;
    n_checks++;
    if (b1.in_ready !== 1'b1) $display("FAIL midrst_in_ready got %0d expected 1", b1.in_ready); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    m_x = 0;
    m_y = 0;
    clear_all();
    for (int i = 0; i < W * H; i++) add_pix($urandom_range(0, 255), 1'b0, 8);
    drive_stream(1, 0, 1'b0);
    n_checks++;
    if (timeout || got_ii.size() != exp_ii.size()) $display("FAIL post_count got %0d expected %0d", got_ii.size(), exp_ii.size()); else n_pass++;
    for (int i = 0; i < exp_ii.size() && i < got_ii.size(); i++) begin
      n_checks++;
      if (got_ii[i] !== exp_ii[i] || got_sq[i] !== exp_sq[i] || got_x[i] !== exp_x[i] || got_y[i] !== exp_y[i] || got_eof[i] !== exp_eof[i])
        $display("FAIL post_out[%0d] got ii=%0d sq=%0d x=%0d y=%0d expected ii=%0d sq=%0d x=%0d y=%0d", i, got_ii[i], got_sq[i], got_x[i], got_y[i], exp_ii[i], exp_sq[i], exp_x[i], exp_y[i]);
      else n_pass++;
    end
  endtask

  initial begin
    b0.in_valid = 1'b0; b0.in_pix = '0; b0.in_sof = 1'b0; b0.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.in_pix = '0; b1.in_sof = 1'b0; b1.out_ready = 1'b1;
    m_x = 0;
    m_y = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_allconst();
    test_ramp();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_sof_mid();
    test_wrap_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
